// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose: initiator side of the instruction-memory read interface. Owns the
// fetch PC, drives a word-aligned address into a combinational instruction
// memory, buffers each returned word together with its PC in a prefetch FIFO
// and hands entries to decode over a valid/ready handshake. Redirects flush
// the FIFO and reload the PC. A halt request stops new fetches until the
// next redirect.
//
// Optional feature macro: IFU_PERF_COUNTERS_EN adds FetchCount/StallCount.
//
// Ports:
//   Clk              clock, all state updates on the rising edge
//   Rst              synchronous, active-high reset
//   FetchAddress     address to instruction memory (the internal fetch PC)
//   FetchInstruction instruction memory read data for FetchAddress
//   RedirectValid    branch/jump taken this cycle
//   RedirectTarget   new PC (bits [1:0] ignored)
//   HaltReq          stop issuing new fetches
//   OutValid         head FIFO entry valid
//   OutReady         decode accepts head entry
//   OutInstruction   head entry instruction (0 while empty)
//   OutPC            head entry PC (0 while empty)
//   OutPCPlus4       OutPC + 4 modulo 2^32 (0 while empty)
//   Halted           fetch FSM is in HALTED
//   FetchCount       (optional) number of pushes, wraps at 2^32
//   StallCount       (optional) RUN cycles stalled on a full FIFO
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] FetchAddress,
  input  logic [31:0] FetchInstruction,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  input  logic        HaltReq,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstruction,
  output logic [31:0] OutPC,
  output logic [31:0] OutPCPlus4,
  output logic        Halted
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_fifo_pc    [DEPTH];

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_head_instr;
  logic [31:0]   w_head_pc;

  assign w_valid = (r_count != {(AW+1){1'b0}});
  assign w_pop   = w_valid & OutReady;
  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign w_push  = (r_state == ST_RUN) & ~HaltReq & ~RedirectValid &
                   ((r_count < DEPTH_C) | w_pop);

  assign w_head_instr = r_fifo_instr[r_rptr];
  assign w_head_pc    = r_fifo_pc[r_rptr];

  assign FetchAddress   = r_pc;
  assign OutValid       = w_valid;
  assign OutInstruction = w_valid ? w_head_instr : 32'h0000_0000;
  assign OutPC          = w_valid ? w_head_pc : 32'h0000_0000;
  assign OutPCPlus4     = w_valid ? (w_head_pc + 32'h0000_0004) : 32'h0000_0000;
  assign Halted         = (r_state == ST_HALTED);

  // FIFO storage: written on push only, contents are don't-care while empty.
  always_ff @(posedge Clk) begin
    if (w_push && !Rst) begin
      r_fifo_instr[r_wptr] <= FetchInstruction;
      r_fifo_pc[r_wptr]    <= r_pc;
    end
  end

  // Fetch FSM, PC, pointers and occupancy; redirect overrides all but reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_count <= {(AW+1){1'b0}};
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
    end else if (RedirectValid) begin
      // Flush; a pop in this cycle is discarded along with the rest.
      r_pc    <= RedirectTarget & 32'hFFFF_FFFC;
      r_count <= {(AW+1){1'b0}};
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      // HALTED always resumes; RUN with a concurrent halt lands in HALTED.
      if (r_state == ST_RUN && HaltReq) begin
        r_state <= ST_HALTED;
      end else begin
        r_state <= ST_RUN;
      end
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + 32'h0000_0004;
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (r_state == ST_RUN && HaltReq) begin
        r_state <= ST_HALTED;
      end
    end
  end

`ifdef IFU_PERF_COUNTERS_EN
  logic w_stall;
  assign w_stall = (r_state == ST_RUN) & ~HaltReq & ~RedirectValid &
                   (r_count == DEPTH_C) & ~w_pop;

  // Performance counters, free-running and wrapping at 2^32.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      FetchCount <= 32'h0000_0000;
      StallCount <= 32'h0000_0000;
    end else begin
      if (w_push) begin
        FetchCount <= FetchCount + 32'h0000_0001;
      end
      if (w_stall) begin
        StallCount <= StallCount + 32'h0000_0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] FetchAddress;
  logic [31:0] FetchInstruction;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic        HaltReq;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstruction;
  logic [31:0] OutPC;
  logic [31:0] OutPCPlus4;
  logic        Halted;
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  // Memory model: word at address a is a ^ key (key = 0 gives memory[i] = i*4).
  logic [31:0] key = 32'h0000_0000;
  assign FetchInstruction = FetchAddress ^ key;

  always #5 Clk = ~Clk;

  instruction_fetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .Clk(Clk), .Rst(Rst), .FetchAddress(FetchAddress),
    .FetchInstruction(FetchInstruction), .RedirectValid(RedirectValid),
    .RedirectTarget(RedirectTarget), .HaltReq(HaltReq), .OutValid(OutValid),
    .OutReady(OutReady), .OutInstruction(OutInstruction), .OutPC(OutPC),
    .OutPCPlus4(OutPCPlus4), .Halted(Halted)
`ifdef IFU_PERF_COUNTERS_EN
    , .FetchCount(FetchCount), .StallCount(StallCount)
`endif
  );

  // Scoreboard: {instruction, pc} of every entry expected in the FIFO.
  logic [63:0] q[$];
  logic [31:0] m_pc;
  logic        m_halted;
  logic [31:0] m_fc;
  logic [31:0] m_sc;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ev;
    ev = (q.size() != 0) ? 32'd1 : 32'd0;
    chk("valid", {31'd0, OutValid}, ev);
    chk("halted", {31'd0, Halted}, {31'd0, m_halted});
    chk("fetch_addr", FetchAddress, m_pc);
    if (q.size() != 0) begin
      chk("out_instr", OutInstruction, q[0][63:32]);
      chk("out_pc", OutPC, q[0][31:0]);
      chk("out_pc4", OutPCPlus4, q[0][31:0] + 32'd4);
    end else begin
      chk("empty_instr", OutInstruction, 32'd0);
      chk("empty_pc", OutPC, 32'd0);
      chk("empty_pc4", OutPCPlus4, 32'd0);
    end
`ifdef IFU_PERF_COUNTERS_EN
    chk("fetch_count", FetchCount, m_fc);
    chk("stall_count", StallCount, m_sc);
`endif
  endtask

  // Advance the reference model by one clock using the inputs now driven.
  task automatic update_model();
    logic pop_v;
    logic push_v;
    pop_v = (q.size() != 0) && OutReady;
    if (Rst) begin
      q.delete();
      m_pc = RESET_PC;
      m_halted = 1'b0;
      m_fc = 32'd0;
      m_sc = 32'd0;
    end else if (RedirectValid) begin
      q.delete();
      m_pc = RedirectTarget & 32'hFFFF_FFFC;
      m_halted = !m_halted && HaltReq;
    end else begin
      push_v = !m_halted && !HaltReq && (q.size() < 4 || pop_v);
      if (!m_halted && !HaltReq && q.size() == 4 && !pop_v) m_sc = m_sc + 32'd1;
      if (pop_v) void'(q.pop_front());
      if (push_v) begin
        q.push_back({m_pc ^ key, m_pc});
        m_pc = m_pc + 32'd4;
        m_fc = m_fc + 32'd1;
      end
      if (!m_halted && HaltReq) m_halted = 1'b1;
    end
  endtask

  // One cycle: compare at a quiet point, then clock, then update the model.
  task automatic step();
    #1;
    check_outputs();
    update_model();
    @(posedge Clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    Rst = 1'b1; RedirectValid = 1'b0; RedirectTarget = 32'd0;
    HaltReq = 1'b0; OutReady = 1'b1;
    @(posedge Clk); #1;
    m_pc = RESET_PC; m_halted = 1'b0; m_fc = 32'd0; m_sc = 32'd0;
    step();                                   // reset state checked, Rst still high

    // Reset release and streaming: OutValid one cycle later, PCs 0,4,8...
    Rst = 1'b0;
    step();
    chk("first_valid", {31'd0, OutValid}, 32'd1);
    chk("first_pc", OutPC, 32'h0);
    steps(6);

    // Backpressure from PC 0: exactly four pushes, address holds at 0x10.
    RedirectValid = 1'b1; RedirectTarget = 32'h0; OutReady = 1'b0;
    step();
    RedirectValid = 1'b0;
    steps(10);
    chk("bp_hold_addr", FetchAddress, 32'h10);
    OutReady = 1'b1;
    steps(6);

    // Redirect with a pop on a full FIFO, unaligned target 0x37.
    key = 32'h1234_0000;
    OutReady = 1'b0;
    steps(5);
    OutReady = 1'b1; RedirectValid = 1'b1; RedirectTarget = 32'h37;
    step();
    RedirectValid = 1'b0;
    chk("rd_valid", {31'd0, OutValid}, 32'd0);
    chk("rd_addr", FetchAddress, 32'h34);
    step();
    chk("rd_first_pc", OutPC, 32'h34);
    steps(4);

    // Halt with three entries buffered; HaltReq drops but HALTED persists.
    OutReady = 1'b0; RedirectValid = 1'b1; RedirectTarget = 32'h100;
    step();
    RedirectValid = 1'b0;
    steps(3);
    HaltReq = 1'b1;
    step();
    HaltReq = 1'b0; OutReady = 1'b1;
    steps(4);
    chk("halt_flag", {31'd0, Halted}, 32'd1);
    chk("halt_drained", {31'd0, OutValid}, 32'd0);
    chk("halt_addr", FetchAddress, 32'h10C);
    RedirectValid = 1'b1; RedirectTarget = 32'h10;
    step();
    RedirectValid = 1'b0;
    step();
    chk("resume_pc", OutPC, 32'h10);
    steps(2);

    // Redirect and halt together: new PC loaded, FIFO empty, HALTED.
    RedirectValid = 1'b1; RedirectTarget = 32'h200; HaltReq = 1'b1;
    step();
    RedirectValid = 1'b0; HaltReq = 1'b0;
    steps(3);
    chk("rdh_addr", FetchAddress, 32'h200);

    // All-zero word is buffered like any other (key makes word at 0x40 zero).
    key = 32'h0000_0040;
    RedirectValid = 1'b1; RedirectTarget = 32'h40;
    step();
    RedirectValid = 1'b0;
    step();
    chk("nop_instr", OutInstruction, 32'h0);
    steps(2);

    // Address wrap, then reset in the middle of the stream.
    RedirectValid = 1'b1; RedirectTarget = 32'hFFFF_FFFC;
    step();
    RedirectValid = 1'b0;
    step();
    chk("wrap_pc", OutPC, 32'hFFFF_FFFC);
    chk("wrap_pc4", OutPCPlus4, 32'h0);
    steps(3);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("rst_valid", {31'd0, OutValid}, 32'd0);
    chk("rst_addr", FetchAddress, RESET_PC);
    steps(4);

`ifdef IFU_PERF_COUNTERS_EN
    // Perf counters: 20 cycles from reset, OutReady low in cycles 5..9.
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      OutReady = (c >= 5 && c <= 9) ? 1'b0 : 1'b1;
      step();
    end
    OutReady = 1'b1;
    chk("perf_fetch_final", FetchCount, m_fc);
    chk("perf_stall_final", StallCount, m_sc);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Owns the program counter and drives a word-aligned fetch address into the combinational instruction memory. Captures each returned word, with its PC, into a small prefetch FIFO and hands entries to decode over a valid/ready handshake. Handles branch/jump redirects by flushing the FIFO, and supports a halt request from the control unit.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, 2..16)
RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)

Ports:
Clk  input  1  single clock, all state updates on rising edge
Rst  input  1  synchronous, active-high reset
FetchAddress  output  32  address to instruction memory; always equals internal fetch PC
FetchInstruction  input  32  instruction memory read data; combinational function of FetchAddress
RedirectValid  input  1  branch/jump taken this cycle
RedirectTarget  input  32  new PC; bits [1:0] forced to 0 internally
HaltReq  input  1  stop issuing new fetches
OutValid  output  1  head FIFO entry valid
OutReady  input  1  decode accepts head entry
OutInstruction  output  32  head entry instruction
OutPC  output  32  head entry PC
OutPCPlus4  output  32  OutPC + 4, modulo 2^32
Halted  output  1  FSM in HALTED

Behaviour:
- Clocking and reset: one clock, Clk; reset Rst is synchronous, active-high.
- Reset values: fetch PC = RESET_PC; FIFO count = 0; read/write pointers = 0; state = RUN.
- Outputs after reset: OutValid = 0; Halted = 0; OutInstruction, OutPC and OutPCPlus4 = 0 while empty (outputs forced to 0 whenever the FIFO is empty).
- pop = OutValid & OutReady.
- push = (state==RUN) & !HaltReq & !RedirectValid & (count<DEPTH | pop).
  - Push writes {FetchInstruction, fetch PC} at the write pointer.
  - Fetch PC += 4 (wraps 32'hFFFF_FFFC -> 0).
- Latency: a word fetched in cycle N appears with OutValid=1 in cycle N+1. With OutReady held high, sustained throughput is one instruction per cycle.
- Full with pop in the same cycle: push is allowed and count stays DEPTH.
- Full without pop: no push; fetch PC and FetchAddress hold.
- Empty: OutValid=0; OutReady is ignored.
- Count update: count' = count + push - pop. Pointers wrap modulo DEPTH.
- OutValid = (count != 0). Head outputs come from registered storage, with no combinational path from FetchInstruction to the Out* ports.
- Redirect has priority over everything except Rst:
  - FIFO cleared (count=0, pointers=0) and fetch PC = {RedirectTarget[31:2],2'b00}.
  - No push that cycle. A simultaneous pop is discarded and not counted.
  - OutValid=0 next cycle. The first target word is valid two cycles after the redirect cycle.
- FSM:
  - RUN -> HALTED when HaltReq=1 and RedirectValid=0. No push in that cycle.
  - HALTED: no pushes, FetchAddress holds, buffered entries keep draining via pop. Halted=1.
  - HALTED -> RUN on RedirectValid (flush and load target, as above). HaltReq is ignored while HALTED.
  - RUN with RedirectValid and HaltReq both high: redirect taken, then HALTED with the new PC loaded and the FIFO empty.
- Rst mid-operation: all in-flight entries dropped; state = RUN at RESET_PC the next cycle.
- Instruction contents are not interpreted; an all-zero word (nop) is buffered like any other.

Optional Feature:
IFU_PERF_COUNTERS_EN
- Defined: adds outputs FetchCount[31:0] and StallCount[31:0], both reset to 0.
  - FetchCount increments on every push.
  - StallCount increments each RUN cycle with HaltReq=0, RedirectValid=0, count==DEPTH and no pop.
  - Both wrap at 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset then stream: memory[i]=i*4, RESET_PC=0, OutReady=1 -> OutValid rises 1 cycle after reset release; OutPC sequence 0,4,8,...; OutInstruction equals OutPC; OutPCPlus4 = OutPC+4.
- Backpressure: OutReady=0 for 10 cycles, DEPTH=4 -> exactly 4 pushes, FetchAddress holds at 0x10. Release OutReady -> in-order 0,4,8,0xC,0x10 with no gap or duplicate.
- Redirect with pop: full FIFO, OutReady=1, RedirectValid=1, RedirectTarget=0x37 -> next cycle OutValid=0 and FetchAddress=0x34. Following cycle OutPC=0x34. Discarded entries never reappear.
- Halt and resume: HaltReq=1 with 3 entries buffered -> Halted=1, 3 pops drain, then OutValid=0 and FetchAddress frozen. RedirectValid=1, target 0x10 -> RUN, OutPC=0x10 two cycles later.
- Wrap and reset: RedirectTarget=0xFFFF_FFFC -> OutPC 0xFFFF_FFFC then 0x0, with OutPCPlus4=0x0 for the first. Assert Rst mid-stream -> OutValid=0 next cycle; restart from RESET_PC.
- With IFU_PERF_COUNTERS_EN defined: 20-cycle run with OutReady low cycles 5-9 -> FetchCount and StallCount match the bench's reference-model tallies exactly.
